// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } ldr_state_t;

    localparam int LEN_W              = 16;
    localparam int DEFAULT_IMEM_DEPTH = 64;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_valid_o flags the
// cycle the fourth byte arrives, with the completed word presented alongside.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [23:0] low_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 2'd0;
            low_q <= 24'd0;
        end else if (clr_i) begin
            cnt_q <= 2'd0;
            low_q <= 24'd0;
        end else if (byte_vld_i) begin
            case (cnt_q)
                2'd0:    low_q[7:0]   <= byte_i;
                2'd1:    low_q[15:8]  <= byte_i;
                2'd2:    low_q[23:16] <= byte_i;
                default: low_q        <= low_q;
            endcase
            cnt_q <= cnt_q + 2'd1;
        end
    end

    // The top byte bypasses storage so the word is ready on the 4th byte itself.
    assign word_valid_o = byte_vld_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, low_q};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte image, writes it to
// imem word by word and releases the core from reset only after a clean load.
module imem_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    ldr_state_t        state_q;
    logic [7:0]        len_lo_q;
    logic [LEN_W-1:0]  len_q;
    logic [7:0]        csum_q;
    logic [ADDR_W:0]   widx_q;
    logic [ADDR_W:0]   wcnt_q;
    logic              wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              done_q;
    logic              error_q;
    logic              hold_q;

    logic              xfer;
    logic              load_go;
    logic              pk_vld;
    logic              pk_word_vld;
    logic [31:0]       pk_word;
    logic [LEN_W-1:0]  len_full;
    logic              len_bad;
    logic              last_word;

    assign rx_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == DATA)   || (state_q == CHECK);
    assign busy     = rx_ready;
    assign xfer     = rx_valid && rx_ready;
    assign load_go  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    assign pk_vld   = xfer && (state_q == DATA);

    assign len_full  = {rx_data, len_lo_q};
    assign len_bad   = (len_full == '0) || (len_full > LEN_W'(IMEM_DEPTH));
    assign last_word = (LEN_W'(widx_q) == (len_q - LEN_W'(1)));

    word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (load_go),
        .byte_vld_i   (pk_vld),
        .byte_i       (rx_data),
        .word_valid_o (pk_word_vld),
        .word_o       (pk_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            len_lo_q <= 8'd0;
            len_q    <= '0;
            csum_q   <= 8'd0;
            widx_q   <= '0;
            wcnt_q   <= '0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            wren_q <= 1'b0;
            // word_count follows completed writes, one cycle behind the capture.
            if (wren_q) begin
                wcnt_q <= wcnt_q + (ADDR_W+1)'(1);
            end
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q  <= LEN_LO;
                        done_q   <= 1'b0;
                        error_q  <= 1'b0;
                        hold_q   <= 1'b1;
                        len_lo_q <= 8'd0;
                        len_q    <= '0;
                        csum_q   <= 8'd0;
                        widx_q   <= '0;
                        wcnt_q   <= '0;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_lo_q <= rx_data;
                        state_q  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_q <= len_full;
                        if (len_bad) begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ rx_data;
                        if (pk_word_vld) begin
                            wren_q  <= 1'b1;
                            addr_q  <= widx_q[ADDR_W-1:0];
                            wdata_q <= pk_word;
                            widx_q  <= widx_q + (ADDR_W+1)'(1);
                            if (last_word) begin
                                state_q <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        if (rx_data == csum_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_wren  = wren_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_hold  = hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, error paths, gaps, reset and full depth.
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_wren;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    int total = 0;
    int bad   = 0;
    int stalls = 0;

    int          wr_n = 0;
    logic [AW-1:0] wr_addr [0:127];
    logic [31:0]   wr_data [0:127];
    logic [31:0]   fw [0:63];

    imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_wren  (imem_wren),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_wren === 1'b1) begin
            if (wr_n < 128) begin
                wr_addr[wr_n] = imem_addr;
                wr_data[wr_n] = imem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        bit   ok;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            stalls = stalls + 1;
        end
        rx_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout byte=%02h rx_ready never high (required 1)", b);
        end
    endtask

    task automatic send_frame(input logic [15:0] len, input int n, input bit calc,
                              input logic [7:0] ck, input int maxgap);
        logic [7:0] x;
        logic [31:0] w;
        x = 8'd0;
        send_byte(len[7:0], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        send_byte(len[15:8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        for (int i = 0; i < n; i++) begin
            w = fw[i];
            for (int k = 0; k < 4; k++) begin
                x = x ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            end
        end
        send_byte(calc ? x : ck, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic check_two_writes(input string tag);
        total++;
        if (wr_n !== 2) begin
            bad++;
            $display("FAIL %s_wr_count got=%0d want=2", tag, wr_n);
        end
        total++;
        if (wr_addr[0] !== 6'd0 || wr_data[0] !== 32'h00500013) begin
            bad++;
            $display("FAIL %s_wr0 got=%0d:%08h want=0:00500013", tag, wr_addr[0], wr_data[0]);
        end
        total++;
        if (wr_addr[1] !== 6'd1 || wr_data[1] !== 32'h00100093) begin
            bad++;
            $display("FAIL %s_wr1 got=%0d:%08h want=1:00100093", tag, wr_addr[1], wr_data[1]);
        end
    endtask

    task automatic load_nominal_words();
        fw[0] = 32'h00500013;
        fw[1] = 32'h00100093;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({core_hold, busy, done, error, rx_ready, imem_wren} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags got=%06b want=100000",
                     {core_hold, busy, done, error, rx_ready, imem_wren});
        end
        total++;
        if (word_count !== 7'd0) begin
            bad++;
            $display("FAIL reset_word_count got=%0d want=0", word_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_idle_bytes();
        bit seen;
        seen = 1'b0;
        wr_n = 0;
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_ready !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        tick();
        rx_valid = 1'b0;
        total++;
        if (seen || wr_n !== 0 || core_hold !== 1'b1) begin
            bad++;
            $display("FAIL idle_bytes ready_seen=%0d writes=%0d hold=%0b want 0/0/1",
                     seen, wr_n, core_hold);
        end
    endtask

    task automatic test_nominal();
        load_nominal_words();
        wr_n = 0;
        do_start();
        total++;
        if (busy !== 1'b1 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL nominal_busy got=%0b%0b want=11", busy, rx_ready);
        end
        send_frame(16'd2, 2, 1'b0, 8'hC0, 0);
        check_two_writes("nominal");
        total++;
        if ({done, error, core_hold, busy} !== 4'b1000 || word_count !== 7'd2) begin
            bad++;
            $display("FAIL nominal_done flags=%04b wc=%0d want=1000 wc=2",
                     {done, error, core_hold, busy}, word_count);
        end
    endtask

    task automatic test_bad_checksum();
        load_nominal_words();
        wr_n = 0;
        do_start();
        send_frame(16'd2, 2, 1'b0, 8'hC1, 0);
        check_two_writes("badck");
        total++;
        if ({done, error, core_hold} !== 3'b011) begin
            bad++;
            $display("FAIL badck_flags got=%03b want=011", {done, error, core_hold});
        end
    endtask

    task automatic test_bad_length();
        wr_n = 0;
        do_start();
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL len0_start_clears got=%0b want=0", error);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tick();
        total++;
        if (error !== 1'b1 || rx_ready !== 1'b0 || wr_n !== 0) begin
            bad++;
            $display("FAIL len0 err=%0b rdy=%0b writes=%0d want 1/0/0", error, rx_ready, wr_n);
        end
        do_start();
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        tick();
        total++;
        if (error !== 1'b1 || core_hold !== 1'b1 || wr_n !== 0) begin
            bad++;
            $display("FAIL len65 err=%0b hold=%0b writes=%0d want 1/1/0", error, core_hold, wr_n);
        end
    endtask

    task automatic test_gaps();
        load_nominal_words();
        wr_n = 0;
        do_start();
        send_frame(16'd2, 2, 1'b0, 8'hC0, 3);
        check_two_writes("gaps");
        total++;
        if (done !== 1'b1 || core_hold !== 1'b0 || word_count !== 7'd2) begin
            bad++;
            $display("FAIL gaps_done done=%0b hold=%0b wc=%0d want 1/0/2", done, core_hold, word_count);
        end
    endtask

    task automatic test_reset_mid_load();
        wr_n = 0;
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        reset = 1'b1;
        #1;
        total++;
        if ({core_hold, rx_ready, busy, imem_wren} !== 4'b1000) begin
            bad++;
            $display("FAIL midrst_flags got=%04b want=1000", {core_hold, rx_ready, busy, imem_wren});
        end
        total++;
        if (wr_n !== 1 || wr_addr[0] !== 6'd0 || wr_data[0] !== 32'h00500013) begin
            bad++;
            $display("FAIL midrst_writes n=%0d a0=%0d d0=%08h want 1/0/00500013",
                     wr_n, wr_addr[0], wr_data[0]);
        end
        tick();
        reset = 1'b0;
        tick();
        load_nominal_words();
        wr_n = 0;
        do_start();
        send_frame(16'd2, 2, 1'b0, 8'hC0, 0);
        total++;
        if (done !== 1'b1 || wr_n !== 2 || word_count !== 7'd2) begin
            bad++;
            $display("FAIL midrst_reload done=%0b writes=%0d wc=%0d want 1/2/2", done, wr_n, word_count);
        end
    endtask

    task automatic test_full_depth();
        int errs;
        for (int i = 0; i < 64; i++) begin
            fw[i] = (32'h01010101 * i) ^ 32'hA5C30F00;
        end
        wr_n = 0;
        stalls = 0;
        do_start();
        total++;
        if (core_hold !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL full_hold_after_start hold=%0b done=%0b want 1/0", core_hold, done);
        end
        send_frame(16'h0040, 64, 1'b1, 8'h00, 0);
        total++;
        if (stalls !== 0) begin
            bad++;
            $display("FAIL full_stalls got=%0d want=0", stalls);
        end
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            if (i >= wr_n || wr_addr[i] !== 6'(i) || wr_data[i] !== fw[i]) errs++;
        end
        total++;
        if (wr_n !== 64 || errs !== 0) begin
            bad++;
            $display("FAIL full_writes n=%0d bad_words=%0d want 64/0", wr_n, errs);
        end
        total++;
        if (done !== 1'b1 || core_hold !== 1'b0 || word_count !== 7'd64) begin
            bad++;
            $display("FAIL full_done done=%0b hold=%0b wc=%0d want 1/0/64", done, core_hold, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_idle_bytes();
        test_nominal();
        test_bad_checksum();
        test_bad_length();
        test_gaps();
        test_reset_mid_load();
        test_full_depth();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish (required finish)");
        $fatal(1, "watchdog");
    end

endmodule
